// File: rtl/p2p_pkg.sv
// Shared defaults and FSM encoding for the matrix-multiplier frame loader.
package p2p_pkg;

  localparam int P2P_DATA_W = 8;
  localparam int P2P_N_ELEM = 8;
  localparam int FRAME_LEN  = 2 * P2P_N_ELEM;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/p2p_frame_buf.sv
// Frame buffer: synchronous write, registered read that returns zero when not read.
module p2p_frame_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // The read register doubles as the loader's a_in output, so idle cycles drive zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
    else              rd_data_q <= '0;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/p2p_matrix_loader.sv
// Buffers one host frame, replays it to the multiplier back-to-back, then waits for done.
module p2p_matrix_loader
  import p2p_pkg::*;
#(
  parameter int DATA_W  = P2P_DATA_W,
  parameter int N_ELEM  = P2P_N_ELEM,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] a_in_o,
  output logic              start_o,
  input  logic              mult_done_i,
  output logic              frame_done_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  localparam int FLEN = 2 * N_ELEM;
  localparam int PW   = $clog2(FLEN);
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(FLEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          drain_q, drain_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          start_q, start_d;
  logic          frame_done_q, frame_done_d;
  logic          err_q, err_d;
  logic          wr_en, rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drain_q      <= 1'b0;
      to_cnt_q     <= '0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drain_q      <= drain_d;
      to_cnt_q     <= to_cnt_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drain_d      = drain_q;
    to_cnt_d     = to_cnt_q;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    case (state_q)
      FILL: begin
        if (s_valid_i) begin
          wr_en = 1'b1;
          if (wr_ptr_q == PTR_LAST) begin
            state_d  = STREAM;
            rd_ptr_d = '0;
            drain_d  = 1'b0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      STREAM: begin
        // Reads are issued one cycle ahead; drain_q marks the cycle after the last read.
        if (!drain_q) begin
          rd_en   = 1'b1;
          start_d = 1'b1;
          if (rd_ptr_q == PTR_LAST) drain_d  = 1'b1;
          else                      rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
          state_d  = WAIT_DONE;
          drain_d  = 1'b0;
          to_cnt_d = '0;
        end
      end
      WAIT_DONE: begin
        // mult_done is tested first so it wins over a coincident timeout.
        if (mult_done_i) begin
          frame_done_d = 1'b1;
          state_d      = FILL;
          wr_ptr_d     = '0;
        end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          err_d    = 1'b1;
          state_d  = FILL;
          wr_ptr_d = '0;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  p2p_frame_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (FLEN),
    .AW     (PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (s_data_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (a_in_o)
  );

  assign s_ready_o    = (state_q == FILL);
  assign busy_o       = (state_q != FILL);
  assign start_o      = start_q;
  assign frame_done_o = frame_done_q;
  assign err_o        = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_p2p_matrix_loader.sv
// Directed bench for the frame loader: stimulus pushes expected a_in values, a monitor pops them.
module tb_p2p_matrix_loader;
  import p2p_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] a_in;
  logic       start;
  logic       mult_done;
  logic       frame_done;
  logic       busy;
  logic       err;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int run_len  = 0;
  logic       err_exp;
  logic [7:0] exp_q[$];
  logic [7:0] frame_v [FRAME_LEN];

  always #5 clk = ~clk;

  p2p_matrix_loader #(
    .DATA_W  (8),
    .N_ELEM  (8),
    .TIMEOUT (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .a_in_o       (a_in),
    .start_o      (start),
    .mult_done_i  (mult_done),
    .frame_done_o (frame_done),
    .busy_o       (busy),
    .err_o        (err),
    .state_o      (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every streamed beat must match the scoreboard; idle a_in must be zero.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (start) begin
      run_len++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_in_extra: got %0d want no beat at %0t", a_in, $time);
      end else begin
        chk("a_in", 32'(a_in), 32'(exp_q.pop_front()));
      end
    end else begin
      chk("a_in_idle", 32'(a_in), 32'd0);
      if (run_len != 0) begin
        chk("start_len", 32'(run_len), 32'(FRAME_LEN));
        run_len = 0;
      end
    end
  end

  task automatic set_seq(input int base);
    for (int i = 0; i < FRAME_LEN; i++) frame_v[i] = 8'(base + i);
  endtask

  task automatic send_frame(input bit gaps, input bit spur);
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        s_data  = 8'hEE;
        step();
      end
      chk("s_ready_fill", 32'(s_ready), 32'd1);
      chk("fd_fill", 32'(frame_done), 32'd0);
      if (spur && i == 3) mult_done = 1'b1;
      if (spur && i == 5) mult_done = 1'b0;
      s_valid = 1'b1;
      s_data  = frame_v[i];
      exp_q.push_back(frame_v[i]);
      step();
    end
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  // Called one tick after the last accepted beat; returns in the first WAIT_DONE cycle.
  task automatic stream_phase(input bit spur);
    chk("s_ready_stream", 32'(s_ready), 32'd0);
    chk("start_latency", 32'(start), 32'd0);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    for (int c = 1; c <= FRAME_LEN + 1; c++) begin
      step();
      if (spur && c == 5) mult_done = 1'b1;
      if (spur && c == 7) mult_done = 1'b0;
      if (c == 1) begin
        chk("start_first", 32'(start), 32'd1);
        chk("a_in_first", 32'(a_in), 32'(frame_v[0]));
      end
      chk("fd_stream", 32'(frame_done), 32'd0);
      chk("busy_stream", 32'(busy), 32'd1);
      chk("err_stream", 32'(err), 32'(err_exp));
    end
    s_valid = 1'b0;
    s_data  = 8'h00;
    chk("start_end", 32'(start), 32'd0);
    chk("state_wait", 32'(state), 32'(WAIT_DONE));
  endtask

  task automatic done_phase();
    repeat (5) step();
    chk("fd_wait", 32'(frame_done), 32'd0);
    mult_done = 1'b1;
    step();
    mult_done = 1'b0;
    chk("fd_pulse", 32'(frame_done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("s_ready_done", 32'(s_ready), 32'd1);
    chk("err_done", 32'(err), 32'(err_exp));
    step();
    chk("fd_single", 32'(frame_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    mult_done = 1'b0;
    err_exp   = 1'b0;
    repeat (3) step();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_a_in", 32'(a_in), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(state), 32'(FILL));
    rst = 1'b0;
    step();

    // Continuous load.
    frame_v = '{8'd12, 8'd13, 8'd112, 8'd143, 8'd12, 8'd1, 8'd11, 8'd17,
                8'd13, 8'd18, 8'd10, 8'd15, 8'd16, 8'd17, 8'd33, 8'd23};
    send_frame(1'b0, 1'b0);
    stream_phase(1'b0);
    done_phase();

    // Same data with a gap before every beat.
    send_frame(1'b1, 1'b0);
    stream_phase(1'b0);
    done_phase();

    // 1..16 with spurious mult_done in FILL and STREAM.
    set_seq(1);
    send_frame(1'b0, 1'b1);
    stream_phase(1'b1);
    chk("err_spur", 32'(err), 32'd0);
    done_phase();

    // Timeout: 20 WAIT_DONE cycles without mult_done.
    set_seq(100);
    send_frame(1'b0, 1'b0);
    stream_phase(1'b0);
    for (int i = 0; i < 19; i++) begin
      step();
      chk("err_pre_to", 32'(err), 32'd0);
      chk("fd_pre_to", 32'(frame_done), 32'd0);
    end
    chk("busy_pre_to", 32'(busy), 32'd1);
    step();
    err_exp = 1'b1;
    chk("err_to", 32'(err), 32'd1);
    chk("fd_to", 32'(frame_done), 32'd0);
    chk("s_ready_to", 32'(s_ready), 32'd1);
    chk("busy_to", 32'(busy), 32'd0);
    mult_done = 1'b1;
    step();
    mult_done = 1'b0;
    chk("fd_late_done", 32'(frame_done), 32'd0);
    chk("err_late_done", 32'(err), 32'd1);
    chk("s_ready_late", 32'(s_ready), 32'd1);

    // Reset while the 4th element (143) is on a_in.
    frame_v = '{8'd12, 8'd13, 8'd112, 8'd143, 8'd12, 8'd1, 8'd11, 8'd17,
                8'd13, 8'd18, 8'd10, 8'd15, 8'd16, 8'd17, 8'd33, 8'd23};
    send_frame(1'b0, 1'b0);
    repeat (4) step();
    chk("a_in_before_rst", 32'(a_in), 32'd143);
    rst = 1'b1;
    #1;
    exp_q.delete();
    err_exp = 1'b0;
    chk("mid_rst_start", 32'(start), 32'd0);
    chk("mid_rst_a_in", 32'(a_in), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    step();
    rst = 1'b0;
    set_seq(7);
    send_frame(1'b0, 1'b0);
    stream_phase(1'b0);
    done_phase();

    step();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
